// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: line-format constants shared by the UART Tx and Rx paths,
// the bit-period derivation, and the Tx FSM state encoding.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 100_000_000;
  localparam int unsigned DEFAULT_BAUD     = 9600;

  // Sysclk cycles per bit, rounded to nearest (10417 at the defaults).
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO ahead of the Tx shift register.
// Push on full and pop on empty are ignored; pointers wrap modulo DEPTH.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; only entries below count are ever read.
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | data bits 0..7, LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | STOP_BITS stop bits (high); chains straight into START if queued
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD       = DEFAULT_BAUD,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          TxSerial,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  // Reject configurations the frame logic is not built for.
  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1 || CLKS_PER_BIT < 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx: unsupported parameter set");
  end

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_q, shift_n;
  logic             tx_n;
  logic             bit_end;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .sysclk (sysclk),
    .rst    (rst),
    .push   (tx_valid),
    .pop    (fifo_pop),
    .din    (tx_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state != ST_IDLE) || (fifo_count != '0);
  assign bit_end  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // State register plus the bit-timing datapath and the registered line.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      TxSerial <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift_q  <= shift_n;
      TxSerial <= tx_n;
    end
  end

  // Next-state: every bit state advances on the last cycle of its bit period.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_n = ST_START;
      ST_START: if (bit_end) state_n = ST_DATA;
      ST_DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = ST_PARITY;
`else
          state_n = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_n = ST_STOP;
`endif
      ST_STOP: begin
        if (bit_end && bit_idx == 3'(STOP_BITS - 1))
          state_n = fifo_empty ? ST_IDLE : ST_START;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs: pop, next line level, counter and bit index updates.
  always_comb begin
    fifo_pop   = 1'b0;
    baud_cnt_n = bit_end ? '0 : baud_cnt + CNT_W'(1);
    bit_idx_n  = bit_idx;
    shift_n    = shift_q;
    tx_n       = TxSerial;
    case (state)
      ST_IDLE: begin
        baud_cnt_n = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_n   = fifo_dout;
          bit_idx_n = '0;
          tx_n      = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_idx_n = '0;
          tx_n      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
            tx_n = (PARITY_ODD != 0) ? ~^shift_q : ^shift_q;
`else
            tx_n = 1'b1;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift_q[bit_idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          bit_idx_n = '0;
          tx_n      = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            bit_idx_n = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_n  = fifo_dout;
              tx_n     = 1'b0;
            end else begin
              tx_n = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        baud_cnt_n = '0;
        tx_n       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. CLK_FREQ/BAUD are scaled down so a
// bit lasts 16 cycles. Stimulus queues expected frames; an independent line
// receiver decodes TxSerial and checks each frame against the queue.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned CLK_FREQ   = 1600;
  localparam int unsigned BAUD       = 100;
  localparam int          N          = 16;    // (1600 + 50) / 100
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * N;

  logic       sysclk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       TxSerial;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  bit mon_go = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } exp_t;
  exp_t exp_q[$];

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH),
    .STOP_BITS  (STOP_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .TxSerial   (TxSerial),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit b2b, output int acc_cyc);
    int g;
    g = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && g < 4 * FRAME) begin
      step();
      g++;
    end
    check("send_ready_timeout", 32'(g < 4 * FRAME), 1);
    exp_q.push_back('{data: d, b2b: b2b});
    step();
    acc_cyc  = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic mon_wait(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      if (!rst) ab = 1'b1;
    end
  endtask

  // Line receiver: samples each bit at its middle, drops frames cut by reset.
  initial begin : monitor
    logic [7:0] got;
    logic       s_bit, stop_bit, par_bit;
    bit         ab;
    int         start_c;
    int         prev_start;
    exp_t       e;
    prev_start = -100000;
    par_bit    = 1'b0;
    wait (mon_go);
    forever begin
      @(negedge sysclk);
      if (rst && TxSerial == 1'b0) begin
        start_c = cyc;
        ab = 1'b0;
        mon_wait(N / 2, ab);
        s_bit = TxSerial;
        for (int i = 0; i < 8; i++) begin
          mon_wait(N, ab);
          got[i] = TxSerial;
        end
`ifdef UART_TX_PARITY_EN
        mon_wait(N, ab);
        par_bit = TxSerial;
`endif
        mon_wait(N, ab);
        stop_bit = TxSerial;
        if (!ab) begin
          check("frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_start_bit", 32'(s_bit), 0);
            check("frame_data", 32'(got), 32'(e.data));
`ifdef UART_TX_PARITY_EN
            check("frame_parity", 32'(par_bit), 32'((^e.data) ^ (PARITY_ODD != 0)));
`endif
            check("frame_stop_bit", 32'(stop_bit), 1);
            if (e.b2b) check("frame_no_gap", 32'(start_c - prev_start), 32'(FRAME));
          end
          prev_start = start_c;
        end
      end
    end
  end

  initial begin : stim
    int k, lows, g, acc, tmp;
    bit pre;
    int acc_edge [6];

    // Reset held for three edges.
    rst = 1'b0;
    repeat (3) step();
    check("rst_txserial", 32'(TxSerial), 1);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_tx_busy", 32'(tx_busy), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    rst = 1'b1;
    mon_go = 1'b1;
    lows = 0;
    repeat (200) begin
      step();
      if (TxSerial !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("idle_line_high", 32'(lows), 0);

    // Single byte 0xA5.
    send(8'hA5, 1'b0, k);
    check("single_count_after_push", 32'(fifo_count), 1);
    check("single_line_at_accept", 32'(TxSerial), 1);
    step();
    check("single_start_at_k1", 32'(TxSerial), 0);
    check("single_busy_at_k1", 32'(tx_busy), 1);
    check("single_count_after_pop", 32'(fifo_count), 0);
    lows = 0;
    while (TxSerial == 1'b0 && lows < 4 * N) begin
      lows++;
      step();
    end
    check("single_start_len", 32'(lows), 32'(N));
    g = 0;
    while (tx_busy && g < 2 * FRAME) begin
      step();
      g++;
    end
    check("single_busy_fall_edge", 32'(cyc), 32'(k + 1 + FRAME));

    // Back-to-back 0x01..0x06 with tx_valid held high.
    step();
    acc = 0;
    g = 0;
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    while (acc < 6 && g < 3 * FRAME) begin
      pre = tx_ready;
      step();
      if (pre) begin
        acc_edge[acc] = cyc;
        exp_q.push_back('{data: tx_data, b2b: (acc != 0)});
        acc++;
        tx_data = 8'(acc + 1);
      end
      if (g == 4) begin
        check("b2b_accepted_in_5_edges", 32'(acc), 5);
        check("b2b_ready_low_when_full", 32'(tx_ready), 0);
        check("b2b_count_full", 32'(fifo_count), 4);
      end
      g++;
    end
    tx_valid = 1'b0;
    check("b2b_accepted_total", 32'(acc), 6);
    check("b2b_sixth_accept_edge", 32'(acc_edge[5]), 32'(acc_edge[0] + 2 + FRAME));
    g = 0;
    while (tx_busy && g < 8 * FRAME) begin
      step();
      g++;
    end
    check("b2b_busy_fall_edge", 32'(cyc), 32'(acc_edge[0] + 1 + 6 * FRAME));
    check("b2b_all_frames_seen", 32'(exp_q.size()), 0);

    // Reset during data bit 3 of 0xFE with two bytes queued.
    step();
    send(8'hFE, 1'b0, k);
    send(8'h11, 1'b1, tmp);
    send(8'h22, 1'b1, tmp);
    check("abort_count_queued", 32'(fifo_count), 2);
    g = 0;
    while (cyc < k + 4 * N + N / 2 && g < 2 * FRAME) begin
      step();
      g++;
    end
    check("abort_bit3_level", 32'(TxSerial), 1);
    rst = 1'b0;
    step();
    check("abort_line_high", 32'(TxSerial), 1);
    check("abort_fifo_count", 32'(fifo_count), 0);
    check("abort_tx_ready", 32'(tx_ready), 1);
    check("abort_tx_busy", 32'(tx_busy), 0);
    step();
    rst = 1'b1;
    exp_q.delete();
    lows = 0;
    repeat (4 * FRAME) begin
      step();
      if (TxSerial !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("abort_no_further_frames", 32'(lows), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
